// File: rtl/enc_pkg.sv
// Shared constants and state encoding for the serial 8-to-3 index encoder.
package enc_pkg;
  localparam int ENC_WIDTH  = 8;
  localparam int ENC_CODE_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } enc_state_e;
endpackage

// File: rtl/encode83_serial_prio_enc8.sv
// Combinational find-first-set. Outputs the selected index, its one-hot mask,
// and a flag for "exactly one bit set".
module prio_enc8 #(
  parameter int  WIDTH     = 8,
  parameter bit  MSB_FIRST = 1'b1,
  localparam int CODE_W    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]  vec_i,
  output logic [CODE_W-1:0] idx_o,
  output logic [WIDTH-1:0]  mask_o,
  output logic              one_o
);

  // Last match in the scan wins, so scan direction is opposite to priority order.
  always_comb begin
    idx_o = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++)
        if (vec_i[i]) idx_o = CODE_W'(i);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (vec_i[i]) idx_o = CODE_W'(i);
    end
  end

  always_comb begin
    mask_o = '0;
    if (|vec_i) mask_o[idx_o] = 1'b1;
  end

  assign one_o = (|vec_i) && ((vec_i & (vec_i - WIDTH'(1))) == '0);

endmodule

// File: rtl/encode83_serial.sv
// Serialises a multi-hot word into a stream of set-bit indices, one per
// handshake beat, with popcount and last/none flags alongside.
module encode83_serial
  import enc_pkg::*;
#(
  parameter int  WIDTH     = ENC_WIDTH,
  parameter bit  MSB_FIRST = 1'b1,
  localparam int CODE_W    = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CODE_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              out_none,
  output logic [CODE_W:0]   out_count
);

  function automatic logic [CODE_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [CODE_W:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + {{CODE_W{1'b0}}, v[i]};
    return c;
  endfunction

  enc_state_e        state_q;
  logic [WIDTH-1:0]  pending_q;
  logic [CODE_W:0]   count_q;

  logic [CODE_W-1:0] pe_idx;
  logic [WIDTH-1:0]  pe_mask;
  logic              pe_one;
  logic              beat_done;
  logic              is_emit;

  // Index comes only from the captured word, never straight from data_in.
  prio_enc8 #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_prio (
    .vec_i  (pending_q),
    .idx_o  (pe_idx),
    .mask_o (pe_mask),
    .one_o  (pe_one)
  );

  assign is_emit   = (state_q == ST_EMIT);
  assign in_ready  = enable && !rst && (state_q == ST_IDLE);
  assign out_valid = is_emit;
  assign data_out  = pe_idx;
  assign out_none  = is_emit && (pending_q == '0);
  assign out_last  = is_emit && (pe_one || (pending_q == '0));
  assign out_count = count_q;
  assign beat_done = out_valid && out_ready && enable;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      count_q   <= '0;
    end else if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            pending_q <= data_in;
            count_q   <= popcount(data_in);
            state_q   <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (beat_done) begin
            pending_q <= pending_q & ~pe_mask;
            if (out_last) state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encode83_serial.sv
// Self-checking bench for encode83_serial: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_encode83_serial;

  logic       clk = 1'b0;
  logic       rst, enable, in_valid, out_ready;
  logic [7:0] data_in;
  logic       in_ready, out_valid, out_last, out_none;
  logic [2:0] data_out;
  logic [3:0] out_count;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: whether a word is in flight and its remaining codes.
  bit busy = 1'b0;
  int codes[$];
  int cnt_w = 0;
  bit none_w = 1'b0;
  bit acc = 1'b0;

  always #5 clk = ~clk;

  encode83_serial dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_none  (out_none),
    .out_count (out_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic v,
                      input logic [7:0] d, input logic o);
    @(posedge clk);
    #1;
    rst = r; enable = e; in_valid = v; data_in = d; out_ready = o;
    @(negedge clk);
    chk("in_ready", in_ready, e && !r && !busy);
    chk("out_valid", out_valid, busy);
    chk("out_count", out_count, cnt_w);
    if (busy) begin
      chk("data_out", data_out, codes[0]);
      chk("out_last", out_last, codes.size() == 1);
      chk("out_none", out_none, none_w);
    end else begin
      chk("idle_data_out", data_out, 0);
      chk("idle_out_last", out_last, 0);
      chk("idle_out_none", out_none, 0);
    end
    acc = !r && e && !busy && v;
    if (r) begin
      busy = 1'b0; codes.delete(); cnt_w = 0; none_w = 1'b0;
    end else if (e) begin
      if (busy) begin
        if (o) begin
          void'(codes.pop_front());
          if (codes.size() == 0) busy = 1'b0;
        end
      end else if (v) begin
        busy = 1'b1;
        codes.delete();
        for (int i = 7; i >= 0; i--) if (d[i]) codes.push_back(i);
        none_w = (codes.size() == 0);
        if (none_w) codes.push_back(0);
        cnt_w = $countones(d);
      end
    end
  endtask

  initial begin
    bit have;
    logic [7:0] w;
    logic r, e, o;
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; data_in = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);

    // T1 reset with in_valid asserted
    repeat (3) step(1, 1, 1, 8'hA5, 1);
    // T2 single bit
    step(0, 1, 1, 8'b0010_0000, 1);
    repeat (3) step(0, 1, 0, 8'h00, 1);
    // T3 multi-hot
    step(0, 1, 1, 8'hA5, 1);
    repeat (6) step(0, 1, 0, 8'h00, 1);
    // T4 backpressure
    step(0, 1, 1, 8'h81, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'h00, i[0]);
    // T5 zero word, then all ones with an enable gap
    step(0, 1, 1, 8'h00, 1);
    repeat (2) step(0, 1, 0, 8'h00, 1);
    step(0, 1, 1, 8'hFF, 1);
    step(0, 1, 0, 8'h00, 1);
    repeat (3) step(0, 0, 0, 8'h00, 1);
    repeat (9) step(0, 1, 0, 8'h00, 1);
    // T6 reset mid-word, then a fresh word
    step(0, 1, 1, 8'hF0, 1);
    repeat (2) step(0, 1, 0, 8'h00, 1);
    step(1, 1, 0, 8'h00, 1);
    step(0, 1, 0, 8'h00, 1);
    step(0, 1, 1, 8'h02, 1);
    repeat (3) step(0, 1, 0, 8'h00, 1);

    // Randomized traffic; the source holds each word until it is accepted.
    have = 1'b0;
    w = 8'h00;
    for (int n = 0; n < 2000; n++) begin
      if (!have && ($urandom % 2 == 0)) begin
        case ($urandom % 4)
          0: w = 8'($urandom);
          1: w = 8'h00;
          2: w = 8'hFF;
          default: w = 8'(1 << ($urandom % 8));
        endcase
        have = 1'b1;
      end
      r = ($urandom % 100 == 0);
      e = ($urandom % 10 != 0);
      o = ($urandom % 10 < 7);
      step(r, e, have, have ? w : 8'($urandom), o);
      if (acc) have = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
